// File: rtl/param_sp_ram.sv
// Parametrised single-port synchronous RAM with selectable read-during-write
// behaviour, optional output register and a zero-fill clear engine.
module param_sp_ram #(
    parameter int DW             = 8,
    parameter int AW             = 10,
    parameter int RDW_MODE       = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic          rd,
    input  logic          wr,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data_in,
    input  logic          clear,
    output logic [DW-1:0] data_out,
    output logic          rvalid,
    output logic          busy
);

    localparam int DEPTH = 2 ** AW;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam state_t        RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
    localparam logic [AW-1:0] LAST_ADDR   = {AW{1'b1}};

    logic [DW-1:0] mem_r [DEPTH];

    state_t        state_r;
    state_t        state_nxt_s;
    logic [AW-1:0] clr_cnt_r;
    logic [AW-1:0] clr_cnt_nxt_s;

    logic          wr_en_s;
    logic          rd_en_s;
    logic [DW-1:0] rd_data_s;

    logic          pipe_vld_r;
    logic [DW-1:0] pipe_data_r;
    logic          ld_vld_s;
    logic [DW-1:0] ld_data_s;

    // Clear engine next-state: a clear request in CLEAR is ignored so the sweep is never extended.
    always_comb begin
        state_nxt_s   = state_r;
        clr_cnt_nxt_s = clr_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (clear) begin
                    state_nxt_s   = ST_CLEAR;
                    clr_cnt_nxt_s = '0;
                end else begin
                    state_nxt_s   = ST_IDLE;
                    clr_cnt_nxt_s = clr_cnt_r;
                end
            end
            ST_CLEAR: begin
                clr_cnt_nxt_s = clr_cnt_r + AW'(1'b1);
                if (clr_cnt_r == LAST_ADDR) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                clr_cnt_nxt_s = '0;
            end
        endcase
    end

    // Clear engine state, counter and busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= RESET_STATE;
            clr_cnt_r <= '0;
            busy      <= (CLEAR_ON_RESET != 0);
        end else begin
            state_r   <= state_nxt_s;
            clr_cnt_r <= clr_cnt_nxt_s;
            busy      <= (state_nxt_s == ST_CLEAR);
        end
    end

    // User access qualification; no-change mode suppresses the read half of a read+write.
    always_comb begin
        if (cs && !busy) begin
            wr_en_s = wr;
            rd_en_s = rd && !(wr && (RDW_MODE == 2));
        end else begin
            wr_en_s = 1'b0;
            rd_en_s = 1'b0;
        end
    end

    // Read data source: write-first forwards the incoming word, otherwise the pre-edge contents.
    always_comb begin
        if (wr && (RDW_MODE == 1)) begin
            rd_data_s = data_in;
        end else begin
            rd_data_s = mem_r[addr];
        end
    end

    // Storage array: the clear sweep owns the port while busy, so user writes never collide with it.
    always_ff @(posedge clk) begin
        if (state_r == ST_CLEAR) begin
            mem_r[clr_cnt_r] <= '0;
        end else if (wr_en_s) begin
            mem_r[addr] <= data_in;
        end
    end

    // Optional pipeline stage between the array read and the output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld_r  <= 1'b0;
            pipe_data_r <= '0;
        end else begin
            pipe_vld_r <= rd_en_s;
            if (rd_en_s) begin
                pipe_data_r <= rd_data_s;
            end
        end
    end

    // Select what loads the output register depending on the configured latency.
    always_comb begin
        if (OUT_REG != 0) begin
            ld_vld_s  = pipe_vld_r;
            ld_data_s = pipe_data_r;
        end else begin
            ld_vld_s  = rd_en_s;
            ld_data_s = rd_data_s;
        end
    end

    // Output register: data_out only changes when new read data arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
            rvalid   <= 1'b0;
        end else begin
            rvalid <= ld_vld_s;
            if (ld_vld_s) begin
                data_out <= ld_data_s;
            end
        end
    end

endmodule
